range_decode: RTL

RANGE_DECODE -- requirements
Module: range_decode

---
 rtl/range_decode.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/range_decode.sv
// Address range decoder with registered output stage and optional skid buffer.
// Classifies each request against NS regions and counts misses.
module range_decode #(
  parameter int NS = 4,
  parameter int AW = 32,
  parameter int DW = 38,
  parameter logic [NS*AW-1:0] REGION_BASE = {
    2'b11, {(AW-2){1'b0}},
    2'b10, {(AW-2){1'b0}},
    2'b01, {(AW-2){1'b0}},
    2'b00, {(AW-2){1'b0}}
  },
  parameter logic [NS*AW-1:0] REGION_LAST = {
    2'b11, {(AW-2){1'b1}},
    2'b10, {(AW-2){1'b1}},
    2'b01, {(AW-2){1'b1}},
    2'b00, {(AW-2){1'b1}}
  },
  parameter logic [NS-1:0] READ_OK = '1,
  parameter logic [NS-1:0] WRITE_OK = '1,
  parameter bit OPT_SKID = 1'b1,
  parameter bit OPT_LOWPOWER = 1'b0,
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_valid,
  output logic          o_stall,
  input  logic [AW-1:0] i_addr,
  input  logic          i_we,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_stall,
  output logic [NS:0]   o_decode,
  output logic [AW-1:0] o_addr,
  output logic          o_we,
  output logic [DW-1:0] o_data,
  input  logic          i_clr_miss,
  output logic [CW-1:0] o_miss_count
);

  typedef struct packed {
    logic [NS:0]   dec;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] data;
  } req_t;

  logic [NS-1:0] hit;
  logic [NS:0]   dec;
  req_t          in_req;
  req_t          out_q;
  req_t          skid_q;
  logic          out_v;
  logic          skid_v;
  logic          accept;
  logic          out_free;
  logic          miss_acc;
  logic [CW-1:0] cnt;

  always_comb begin
    hit = '0;
    for (int k = 0; k < NS; k++) begin
      hit[k] = (i_addr >= REGION_BASE[k*AW +: AW])
            && (i_addr <= REGION_LAST[k*AW +: AW])
            && (i_we ? WRITE_OK[k] : READ_OK[k]);
    end
  end

  // Walk downwards so the lowest hitting index is written last.
  always_comb begin
    dec = '0;
    dec[NS] = 1'b1;
    for (int k = NS-1; k >= 0; k--) begin
      if (hit[k]) begin
        dec = '0;
        dec[k] = 1'b1;
      end
    end
  end

  assign in_req   = '{dec: dec, addr: i_addr, we: i_we, data: i_data};
  assign o_stall  = OPT_SKID ? skid_v : (out_v && i_stall);
  assign accept   = i_valid && !o_stall;
  assign out_free = !out_v || !i_stall;
  assign miss_acc = accept && dec[NS];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_v <= 1'b0;
      out_q <= '0;
    end else if (out_free) begin
      if (skid_v) begin
        out_v <= 1'b1;
        out_q <= skid_q;
      end else if (accept) begin
        out_v <= 1'b1;
        out_q <= in_req;
      end else begin
        out_v <= 1'b0;
        if (OPT_LOWPOWER)
          out_q <= '0;
      end
    end
  end

  // Skid only fills when the output is held; it drains on the next transfer.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      skid_v <= 1'b0;
      skid_q <= '0;
    end else if (skid_v) begin
      if (!i_stall) begin
        skid_v <= 1'b0;
        if (OPT_LOWPOWER)
          skid_q <= '0;
      end
    end else if (accept && !out_free) begin
      skid_v <= 1'b1;
      skid_q <= in_req;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      cnt <= '0;
    else if (i_clr_miss)
      cnt <= miss_acc ? CW'(1) : '0;
    else if (miss_acc && cnt != {CW{1'b1}})
      cnt <= cnt + CW'(1);
  end

  assign o_valid      = out_v;
  assign o_decode     = out_q.dec;
  assign o_addr       = out_q.addr;
  assign o_we         = out_q.we;
  assign o_data       = out_q.data;
  assign o_miss_count = cnt;

endmodule
